// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and Memoria-side signals of mem_port_arbiter.
// The master modport is the environment side and the slave modport is the arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0, wr0, ack0, req1, wr1, ack1, mem_wr, busy, owner;
    logic [ADDR_W-1:0] addr0, addr1, mem_addr;
    logic [DATA_W-1:0] wdata0, rdata0, wdata1, rdata1, mem_wdata, mem_rdata;
    modport master (
        output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, mem_rdata,
        input  ack0, rdata0, ack1, rdata1, mem_addr, mem_wr, mem_wdata, busy, owner
    );
    modport slave (
        input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, mem_rdata,
        output ack0, rdata0, ack1, rdata1, mem_addr, mem_wr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises two requesters onto single-port Memoria, one access in flight.
// Defining MEM_ARB_STATS_EN adds saturating grant and conflict counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]         grant_cnt0_o,
    output logic [15:0]         grant_cnt1_o,
    output logic [15:0]         conflict_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d, owner_q, owner_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              any_req, gnt1, done;
    always_comb begin
        any_req  = bus.req0 | bus.req1;
        // on a tie round-robin hands the grant to whichever port was not served last
        gnt1     = bus.req1 & (~bus.req0 | ((FIXED_PRIO == 0) & ~last_q));
        done     = cnt_q == 4'(MEM_LAT - 1);
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = ACCESS;
                cnt_d   = '0;
                owner_d = gnt1;
                last_d  = gnt1;
                wr_d    = gnt1 ? bus.wr1 : bus.wr0;
                addr_d  = gnt1 ? bus.addr1 : bus.addr0;
                wdata_d = gnt1 ? bus.wdata1 : bus.wdata0;
            end
            ACCESS: if (done) begin
                state_d  = RESP;
                rdata0_d = (!wr_q && !owner_q) ? bus.mem_rdata : rdata0_q;
                rdata1_d = (!wr_q && owner_q) ? bus.mem_rdata : rdata1_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    assign bus.mem_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    // a single write strobe, in the first ACCESS cycle only
    assign bus.mem_wr    = (state_q == ACCESS) && (cnt_q == 4'd0) && wr_q;
    assign bus.ack0      = (state_q == RESP) && !owner_q;
    assign bus.ack1      = (state_q == RESP) && owner_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.owner     = owner_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (any_req && !gnt1 && grant_cnt0_q != 16'hFFFF) grant_cnt0_q <= grant_cnt0_q + 16'd1;
            if (gnt1 && grant_cnt1_q != 16'hFFFF) grant_cnt1_q <= grant_cnt1_q + 16'd1;
            if (bus.req0 && bus.req1 && conflict_cnt_q != 16'hFFFF) conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    assign grant_cnt0_o   = grant_cnt0_q;
    assign grant_cnt1_o   = grant_cnt1_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for round-robin (MEM_LAT=1), fixed-priority and MEM_LAT=3 instances.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int errors = 0, checks = 0;
    localparam logic [31:0] D = 32'hDEADBEEF, S = 32'h12345678, P = 32'hA5A5A5A5;
    mem_port_arbiter_if ifa(), ifb(), ifc();
`ifdef MEM_ARB_STATS_EN
    logic [15:0] g0 [3], g1 [3], cc [3];
`endif
    mem_port_arbiter #(.MEM_LAT(1), .FIXED_PRIO(0)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0_o(g0[0]), .grant_cnt1_o(g1[0]), .conflict_cnt_o(cc[0])
`endif
    );
    mem_port_arbiter #(.MEM_LAT(1), .FIXED_PRIO(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0_o(g0[1]), .grant_cnt1_o(g1[1]), .conflict_cnt_o(cc[1])
`endif
    );
    mem_port_arbiter #(.MEM_LAT(3), .FIXED_PRIO(0)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0_o(g0[2]), .grant_cnt1_o(g1[2]), .conflict_cnt_o(cc[2])
`endif
    );
    logic [31:0] mem_a [256], mem_b [256], mem_c [256];
    always @(posedge clk) begin
        if (ifa.mem_wr) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
        if (ifb.mem_wr) mem_b[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
        if (ifc.mem_wr) mem_c[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
    end
    assign ifa.mem_rdata = mem_a[ifa.mem_addr[7:0]];
    assign ifb.mem_rdata = mem_b[ifb.mem_addr[7:0]];
    assign ifc.mem_rdata = mem_c[ifc.mem_addr[7:0]];
    typedef struct {
        logic        rst, r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        busy, own, k0, k1, mw;
        logic [31:0] ma, q0, q1;
    } vec_t;
    vec_t tbl [26];
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask
    task automatic idle_inputs();
        {ifa.req0, ifa.wr0, ifa.addr0, ifa.wdata0, ifa.req1, ifa.wr1, ifa.addr1, ifa.wdata1} = '0;
        {ifb.req0, ifb.wr0, ifb.addr0, ifb.wdata0, ifb.req1, ifb.wr1, ifb.addr1, ifb.wdata1} = '0;
        {ifc.req0, ifc.wr0, ifc.addr0, ifc.wdata0, ifc.req1, ifc.wr1, ifc.addr1, ifc.wdata1} = '0;
    endtask
    initial begin
        int n0, n1, lat;
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
            mem_c[i] = 32'h0;
        end
        mem_a[8'h10] = D;
        mem_b[8'h10] = D;
        mem_b[8'h20] = S;
        mem_c[8'h50] = 32'hCAFEF00D;
        mem_c[8'h54] = 32'h0BADBAD0;
        //          rst r0 w0 a0     d0  r1 w1 a1     d1    busy own k0 k1 mw ma     q0 q1
        tbl[0]  = '{1, 0, 0, 0,     0,  0, 0, 0,     0,    0, 0, 0, 0, 0, 0,     0, 0};
        tbl[1]  = '{0, 1, 0, 'h10,  0,  0, 0, 0,     0,    1, 0, 0, 0, 0, 'h10,  0, 0};
        tbl[2]  = '{0, 1, 0, 'h10,  0,  0, 0, 0,     0,    1, 0, 1, 0, 0, 0,     D, 0};
        tbl[3]  = '{0, 0, 0, 'h10,  0,  0, 0, 0,     0,    0, 0, 0, 0, 0, 0,     D, 0};
        tbl[4]  = '{0, 0, 0, 0,     0,  1, 1, 'h20,  S,    1, 1, 0, 0, 1, 'h20,  D, 0};
        tbl[5]  = '{0, 0, 0, 0,     0,  1, 1, 'h20,  S,    1, 1, 0, 1, 0, 0,     D, 0};
        tbl[6]  = '{0, 1, 0, 'h20,  0,  0, 0, 0,     0,    0, 1, 0, 0, 0, 0,     D, 0};
        tbl[7]  = '{0, 1, 0, 'h20,  0,  0, 0, 0,     0,    1, 0, 0, 0, 0, 'h20,  D, 0};
        tbl[8]  = '{0, 1, 0, 'h20,  0,  0, 0, 0,     0,    1, 0, 1, 0, 0, 0,     S, 0};
        tbl[9]  = '{0, 0, 0, 0,     0,  0, 0, 0,     0,    0, 0, 0, 0, 0, 0,     S, 0};
        tbl[10] = '{1, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    0, 0, 0, 0, 0, 0,     0, 0};
        tbl[11] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    1, 0, 0, 0, 0, 'h10,  0, 0};
        tbl[12] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    1, 0, 1, 0, 0, 0,     D, 0};
        tbl[13] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    0, 0, 0, 0, 0, 0,     D, 0};
        tbl[14] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    1, 1, 0, 0, 0, 'h20,  D, 0};
        tbl[15] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    1, 1, 0, 1, 0, 0,     D, S};
        tbl[16] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    0, 1, 0, 0, 0, 0,     D, S};
        tbl[17] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    1, 0, 0, 0, 0, 'h10,  D, S};
        tbl[18] = '{0, 1, 0, 'h10,  0,  1, 0, 'h20,  0,    1, 0, 1, 0, 0, 0,     D, S};
        tbl[19] = '{0, 0, 0, 0,     0,  0, 0, 0,     0,    0, 0, 0, 0, 0, 0,     D, S};
        tbl[20] = '{0, 0, 0, 0,     0,  1, 1, 'h30,  P,    1, 1, 0, 0, 1, 'h30,  D, S};
        tbl[21] = '{0, 0, 0, 0,     0,  0, 0, 'h30,  P,    1, 1, 0, 1, 0, 0,     D, S};
        tbl[22] = '{0, 0, 0, 0,     0,  0, 0, 0,     0,    0, 1, 0, 0, 0, 0,     D, S};
        tbl[23] = '{0, 1, 0, 'h30,  0,  0, 0, 0,     0,    1, 0, 0, 0, 0, 'h30,  D, S};
        tbl[24] = '{0, 1, 0, 'h30,  0,  0, 0, 0,     0,    1, 0, 1, 0, 0, 0,     P, S};
        tbl[25] = '{0, 0, 0, 0,     0,  0, 0, 0,     0,    0, 0, 0, 0, 0, 0,     P, S};
        #2;
        for (int i = 0; i < 26; i++) begin
            rst_a = tbl[i].rst;
            {ifa.req0, ifa.wr0, ifa.addr0, ifa.wdata0} = {tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0};
            {ifa.req1, ifa.wr1, ifa.addr1, ifa.wdata1} = {tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1};
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                128'({ifa.busy, ifa.owner, ifa.ack0, ifa.ack1, ifa.mem_wr, ifa.mem_addr, ifa.rdata0, ifa.rdata1}),
                128'({tbl[i].busy, tbl[i].own, tbl[i].k0, tbl[i].k1, tbl[i].mw, tbl[i].ma, tbl[i].q0, tbl[i].q1}));
        end
        // fixed priority: port 0 keeps winning while it requests
        rst_b = 1'b0;
        {ifb.req0, ifb.addr0, ifb.req1, ifb.addr1} = {1'b1, 32'h10, 1'b1, 32'h20};
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            n0 += int'(ifb.ack0);
            n1 += int'(ifb.ack1);
        end
        chk("fp_acks", 128'({n0, n1}), 128'({32'd3, 32'd0}));
`ifdef MEM_ARB_STATS_EN
        chk("fp_conflicts", 128'({g0[1], cc[1]}), 128'({16'd3, 16'd3}));
`endif
        ifb.req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("fp_grant1", 128'({ifb.busy, ifb.owner, ifb.mem_addr}), 128'({1'b1, 1'b1, 32'h20}));
`ifdef MEM_ARB_STATS_EN
        chk("fp_gcnt1", 128'(g1[1]), 128'(16'd1));
`endif
        @(posedge clk);
        #1;
        chk("fp_ack1", 128'({ifb.ack0, ifb.ack1, ifb.rdata1}), 128'({1'b0, 1'b1, S}));
        ifb.req1 = 1'b0;
        // MEM_LAT=3: reset during the second ACCESS cycle of a write
        rst_c = 1'b0;
        {ifc.req0, ifc.wr0, ifc.addr0, ifc.wdata0} = {1'b1, 1'b1, 32'h40, 32'h77};
        @(posedge clk);
        #1;
        chk("c_wr_strobe", 128'({ifc.busy, ifc.mem_wr, ifc.mem_addr, ifc.mem_wdata}), 128'({1'b1, 1'b1, 32'h40, 32'h77}));
        @(posedge clk);
        #1;
        chk("c_wr_once", 128'({ifc.busy, ifc.mem_wr, ifc.mem_addr}), 128'({1'b1, 1'b0, 32'h40}));
        rst_c = 1'b1;
        #1;
        chk("c_rst_now", 128'({ifc.busy, ifc.mem_wr, ifc.ack0, ifc.ack1, ifc.owner, ifc.mem_addr, ifc.mem_wdata}), 128'(0));
        {ifc.req0, ifc.wr0, ifc.addr0, ifc.wdata0} = '0;
        @(posedge clk);
        #1;
        chk("c_rst_noack", 128'({ifc.busy, ifc.ack0, ifc.ack1}), 128'(0));
        rst_c = 1'b0;
        {ifc.req0, ifc.addr0} = {1'b1, 32'h50};
        lat = 11;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) ifc.addr0 = 32'h54;
            if (ifc.ack0) begin
                lat = k;
                break;
            end
        end
        chk("c_latency", 128'(lat), 128'(4));
        chk("c_rdata", 128'({ifc.ack1, ifc.rdata0}), 128'({1'b0, 32'hCAFEF00D}));
        ifc.req0 = 1'b0;
        @(posedge clk);
        #1;
        chk("c_idle", 128'({ifc.busy, ifc.ack0, ifc.rdata0}), 128'({1'b0, 1'b0, 32'hCAFEF00D}));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port Memoria between two requesters: port 0 is the CPU (fetch/data path, IouD-selected address) and port 1 is a secondary master (program loader / debug DMA).
- Serialises accesses, counts Memoria read latency, and returns read data with a one-cycle ack pulse.
- Sits between the requesters and Memoria's Address/Wr/DataIn/DataOut pins.
- Exactly one access is in flight at any time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, Memoria cycles from address presented to DataOut valid; legal range 1..15.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- wr0  in  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DATA_W  port 0 read data; valid while ack0=1, held afterwards.
- req1, wr1, addr1, wdata1, ack1, rdata1: same meanings, for port 1.
- mem_addr  out  ADDR_W  to Memoria Address.
- mem_wr  out  1  to Memoria Wr.
- mem_wdata  out  DATA_W  to Memoria DataIn.
- mem_rdata  in  DATA_W  from Memoria DataOut.
- busy  out  1  an access is in progress (state is not IDLE).
- owner  out  1  port currently or most recently granted.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie; latency counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high at the edge, pick a winner, latch its wr/addr/wdata, set owner, and go to ACCESS. Otherwise stay.
  - Arbitration with FIXED_PRIO=0: single request wins; on a tie the port that is not last_grant wins. last_grant updates on grant.
  - Arbitration with FIXED_PRIO=1: port 0 wins every tie.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values.
  - mem_wr equals the latched wr in the first ACCESS cycle only, and is 0 afterwards (exactly one write strobe per write).
  - Counter runs 0..MEM_LAT-1. At MEM_LAT-1, capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
- RESP:
  - ack of the owner = 1 for exactly one cycle, then go to IDLE.
  - Writes also ack; rdata is unchanged on a write.
- Latency: req sampled high at edge N in IDLE gives ack high during cycle N+MEM_LAT+1. Minimum request-to-request spacing is MEM_LAT+2 cycles.
- Requester rule: deassert req on the edge where ack is seen. A req still high in IDLE is treated as a new request.
- Losing requester: keeps req high and is served next. No request is dropped.
- Starvation bound (round-robin): one access of the other port.
- req dropped mid-access: the access still completes, the write takes effect, and ack still pulses.
- Inputs changing during ACCESS have no effect, because the values are latched.
- Reset mid-access: access aborted, no ack, mem_wr forced to 0 immediately.
- In IDLE: mem_addr=0, mem_wr=0, mem_wdata=0.
- Never are ack0 and ack1 high together. Never is mem_wr high outside ACCESS.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds outputs:
  - grant_cnt0 and grant_cnt1 (16 bits each): saturating counts of grants per port.
  - conflict_cnt (16 bits): saturating count of IDLE cycles in which both reqs are high.
  - All three clear on Reset.
- When not defined, these ports and their logic are absent; core behaviour is identical either way.

Test Plan:
- Single read, MEM_LAT=1: Memoria[0x10]=0xDEADBEEF; pulse req0 read addr0=0x10 at cycle 0 -> ack0 high in cycle 2, rdata0=0xDEADBEEF, mem_wr never high.
- Write then read: port 1 writes 0x12345678 to 0x20 -> mem_wr high exactly one cycle with mem_addr=0x20, ack1 at cycle 2; a following port 0 read of 0x20 returns 0x12345678.
- Tie, round-robin: req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1, with acks every 3 cycles; conflict_cnt increments per tie when MEM_ARB_STATS_EN is defined.
- FIXED_PRIO=1, both requesting: port 0 re-requests right after each ack -> port 1 is granted only when req0 is low in IDLE.
- MEM_LAT=3: read issued at cycle 0 -> ack at cycle 4; rdata equals the Memoria value at the latched address even if addr0 changes at cycle 2.
- Reset asserted in the second ACCESS cycle of a write -> all outputs 0 at once, no ack, busy=0, and the next request after reset is served normally.
